sd_tag_scanner: RTL and testbench
=================================

// Module: sd_tag_scanner
// PURPOSE
// Scans consecutive SD blocks from START_BLOCK and finds the first block whose leading TAG_LEN bytes equal TAG.
// Each block is read through the sd_card controller into a 512-byte internal buffer.
// On a match, streams the payload (bytes TAG_LEN..511, up to a NUL) over a valid/ready byte port to a UART sender.
// Reports the matching block address. Sits between sd_card and the UART print FSM in the top level.
// PARAMETERS
// START_BLOCK  32'd0                  first block address scanned
// MAX_BLOCKS   1024                   blocks scanned before giving up (>=1)
// TAG_LEN      8                      signature length in bytes (1..16)
// TAG          64'h444C41425F544147   signature, byte 0 in MSBs ("DLAB_TAG"); width 8*TAG_LEN
// STOP_ON_NUL  1                      1: stream ends at first 0x00 (not sent); 0: stream to byte 511
// PORTS
// clk            in   1   system clock
// reset          in   1   synchronous, active-low reset
// start          in   1   1-cycle pulse; begins a scan when idle and sd_init_finish=1
// busy           out  1   high from accepted start until done pulse
// sd_init_finish in   1   sd_card initialised
// sd_rd_req      out  1   block read request to sd_card
// sd_block_addr  out  32  block address to sd_card
// sd_dout        in   8   read data byte from sd_card
// sd_out_valid   in   1   sd_dout valid this cycle
// out_data       out  8   payload byte
// out_valid      out  1   out_data valid
// out_ready      in   1   sink accepts byte when out_valid&&out_ready
// done           out  1   1-cycle pulse at scan end
// found          out  1   with/after done: 1 = tag matched; held until next start
// match_addr     out  32  matching block address; valid while found=1
// BEHAVIOUR
// - Reset (reset=0 at posedge): state IDLE, all outputs 0, sd_block_addr=START_BLOCK, counters cleared. Mid-operation reset aborts the scan; no partial stream, no done pulse.
// - FSM states: IDLE -> REQ -> READ -> CHECK -> (REQ | STREAM | FIN) ; STREAM -> FIN ; FIN -> IDLE.
// - IDLE: start && sd_init_finish -> REQ; sd_block_addr<=START_BLOCK, found<=0, blk_cnt<=0. start while busy or uninitialised is ignored.
// - REQ: sd_rd_req=1 for exactly one cycle, sd_block_addr stable; next state READ.
// - READ: each sd_out_valid writes sd_dout to buf[byte_cnt] and byte_cnt++ (10 bits).
//   Match flag set on entry to READ; cleared when byte_cnt<TAG_LEN and sd_dout != TAG byte[byte_cnt].
//   byte_cnt==512 -> CHECK.
// - CHECK (1 cycle):
//   match -> STREAM, found<=1, match_addr<=sd_block_addr, rd_ptr<=TAG_LEN.
//   else if blk_cnt==MAX_BLOCKS-1 -> FIN with found=0.
//   else sd_block_addr++, blk_cnt++, byte_cnt<=0 -> REQ.
// - STREAM: buffer read has 1-cycle latency; out_valid asserts 1 cycle after rd_ptr is presented.
//   out_data/out_valid hold stable until accepted. On accept, rd_ptr++ and next byte is fetched; out_valid may drop 1 cycle between bytes.
//   Ends -> FIN when rd_ptr reaches 512 after the accept of byte 511, or (STOP_ON_NUL) when the fetched byte is 0x00; the NUL is never presented.
//   A first payload byte of 0x00 gives an empty stream.
// - FIN: done=1 one cycle, busy=0 next cycle, -> IDLE. found/match_addr held until next accepted start.
// - sd_block_addr is 32-bit; START_BLOCK+MAX_BLOCKS-1 wrapping past 2^32-1 wraps modulo 2^32.
// - sd_out_valid outside READ is ignored; buffer is not written.
// TESTING
// 1 tag "DLAB_TAG"+"HI\0" at block 3, START_BLOCK=0 -> 4 reads (0..3); found=1, match_addr=3; stream 'H','I'; done pulse.
// 2 no tag in blocks 0..MAX_BLOCKS-1 (MAX_BLOCKS=4) -> exactly 4 rd_req pulses; done=1, found=0; out_valid never high.
// 3 match, out_ready low 20 cycles per byte -> out_data stable while valid; no byte lost or duplicated.
// 4 STOP_ON_NUL=0, payload no NUL -> exactly 512-TAG_LEN bytes streamed, last = buf[511].
// 5 partial tag (first 7 bytes match, byte 7 differs) at block 0 -> no match; scan continues to block 1.
// 6 reset=0 mid-READ, then start -> restarts at START_BLOCK; no done pulse before restart; start while busy ignored.

Source files
------------

// File: rtl/sd_tag_scanner.sv
// Scans SD blocks from START_BLOCK for a leading TAG and streams the matching block's payload bytes.
// Per block: 1 request cycle, 512 data beats, 1 check cycle. Each payload byte appears 1 cycle after its fetch and is held until out_ready.
module sd_tag_scanner #(
    parameter logic [31:0]          START_BLOCK = 32'd0,
    parameter int                   MAX_BLOCKS  = 1024,
    parameter int                   TAG_LEN     = 8,
    parameter logic [8*TAG_LEN-1:0] TAG         = 64'h444C41425F544147,
    parameter bit                   STOP_ON_NUL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    input  logic        sd_init_finish,
    output logic        sd_rd_req,
    output logic [31:0] sd_block_addr,
    input  logic [7:0]  sd_dout,
    input  logic        sd_out_valid,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        done,
    output logic        found,
    output logic [31:0] match_addr
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_READ, S_CHECK, S_STREAM, S_FIN} state_t;

    localparam logic [9:0]  TAG_LEN_W = 10'(TAG_LEN);
    localparam logic [31:0] LAST_BLK  = 32'(MAX_BLOCKS - 1);

    state_t      state;
    logic [7:0]  mem [0:511];
    logic [9:0]  byte_cnt;
    logic [9:0]  rd_ptr;
    logic [31:0] blk_cnt;
    logic        match;
    logic [7:0]  tag_byte;
    logic [7:0]  rd_byte;
    logic        buf_we;

    // Signature byte 0 sits in the most significant byte of TAG.
    always_comb begin
        tag_byte = 8'h00;
        for (int i = 0; i < TAG_LEN; i++) begin
            if (byte_cnt == 10'(i)) tag_byte = TAG[8*(TAG_LEN-1-i) +: 8];
        end
    end

    assign buf_we  = (state == S_READ) && sd_out_valid && !byte_cnt[9];
    assign rd_byte = mem[rd_ptr[8:0]];

    always_ff @(posedge clk) begin
        if (buf_we) mem[byte_cnt[8:0]] <= sd_dout;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            sd_rd_req     <= 1'b0;
            sd_block_addr <= START_BLOCK;
            out_data      <= 8'h00;
            out_valid     <= 1'b0;
            done          <= 1'b0;
            found         <= 1'b0;
            match_addr    <= 32'd0;
            byte_cnt      <= 10'd0;
            rd_ptr        <= 10'd0;
            blk_cnt       <= 32'd0;
            match         <= 1'b0;
        end else begin
            done      <= 1'b0;
            sd_rd_req <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && sd_init_finish) begin
                        state         <= S_REQ;
                        busy          <= 1'b1;
                        sd_rd_req     <= 1'b1;
                        sd_block_addr <= START_BLOCK;
                        found         <= 1'b0;
                        match_addr    <= 32'd0;
                        blk_cnt       <= 32'd0;
                    end
                end
                S_REQ: begin
                    state    <= S_READ;
                    byte_cnt <= 10'd0;
                    match    <= 1'b1;
                end
                S_READ: begin
                    if (byte_cnt[9]) begin
                        state <= S_CHECK;
                    end else if (sd_out_valid) begin
                        byte_cnt <= byte_cnt + 10'd1;
                        if (byte_cnt < TAG_LEN_W && sd_dout != tag_byte) match <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (match) begin
                        state      <= S_STREAM;
                        found      <= 1'b1;
                        match_addr <= sd_block_addr;
                        rd_ptr     <= TAG_LEN_W;
                    end else if (blk_cnt == LAST_BLK) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                    end else begin
                        state         <= S_REQ;
                        sd_rd_req     <= 1'b1;
                        sd_block_addr <= sd_block_addr + 32'd1;
                        blk_cnt       <= blk_cnt + 32'd1;
                    end
                end
                S_STREAM: begin
                    // Alternate fetch and present phases; a fetched NUL ends the stream unseen.
                    if (!out_valid) begin
                        if (STOP_ON_NUL && rd_byte == 8'h00) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            out_data  <= rd_byte;
                            out_valid <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        rd_ptr    <= rd_ptr + 10'd1;
                        if (rd_ptr == 10'd511) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_tag_scanner.sv
// Bench for sd_tag_scanner: two instances (NUL-terminated and full-length stream) share one SD responder.
module tb_sd_tag_scanner;

    localparam int          MAXB = 4;
    localparam int          TL   = 8;
    localparam logic [63:0] TAGV = 64'h444C41425F544147;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, sd_init_finish, sd_out_valid, out_ready;
    logic [7:0]  sd_dout;
    logic        busy1, rq1, ov1, dn1, fd1, busy2, rq2, ov2, dn2, fd2;
    logic [31:0] addr1, ma1, addr2, ma2;
    logic [7:0]  od1, od2;

    sd_tag_scanner #(.START_BLOCK(32'd0), .MAX_BLOCKS(MAXB), .TAG_LEN(TL), .TAG(TAGV), .STOP_ON_NUL(1'b1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy1), .sd_init_finish(sd_init_finish),
        .sd_rd_req(rq1), .sd_block_addr(addr1), .sd_dout(sd_dout), .sd_out_valid(sd_out_valid),
        .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .done(dn1), .found(fd1), .match_addr(ma1));

    sd_tag_scanner #(.START_BLOCK(32'd0), .MAX_BLOCKS(MAXB), .TAG_LEN(TL), .TAG(TAGV), .STOP_ON_NUL(1'b0)) u_dut_nonul (
        .clk(clk), .reset(reset), .start(start), .busy(busy2), .sd_init_finish(sd_init_finish),
        .sd_rd_req(rq2), .sd_block_addr(addr2), .sd_dout(sd_dout), .sd_out_valid(sd_out_valid),
        .out_data(od2), .out_valid(ov2), .out_ready(out_ready), .done(dn2), .found(fd2), .match_addr(ma2));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Disk image and behavioural model state
    string       TAG_S = "DLAB_TAG";
    logic [7:0]  disk [0:MAXB-1][0:511];
    logic [7:0]  exp_q1[$];
    logic [7:0]  exp_q2[$];
    int          exp_len [2];
    int          exp_reads;
    int          exp_found;
    int          exp_addr;
    int          rd_seen;
    int          ready_mode;
    int          slow_cnt;
    int          done_cnt [2];
    int          rd_pulses [2];
    int          got_cnt [2];
    int          valid_cyc [2];
    logic [7:0]  last_byte [2];
    logic        pv [2];
    logic [7:0]  pd [2];
    logic        pr;

    task automatic fill_random();
        for (int b = 0; b < MAXB; b++)
            for (int i = 0; i < 512; i++) disk[b][i] = 8'($urandom_range(1, 255));
    endtask

    // good < TL corrupts that byte of the signature
    task automatic put_tag(input int b, input int good);
        for (int k = 0; k < TL; k++) disk[b][k] = TAG_S[k];
        if (good < TL) disk[b][good] = disk[b][good] ^ 8'h20;
    endtask

    task automatic put_payload(input int b, input string s);
        for (int i = 0; i < s.len(); i++) disk[b][TL+i] = s[i];
        disk[b][TL+s.len()] = 8'h00;
    endtask

    task automatic build_model();
        bit ok;
        exp_q1.delete();
        exp_q2.delete();
        exp_found = 0;
        exp_addr  = 0;
        exp_reads = MAXB;
        for (int b = 0; b < MAXB; b++) begin
            ok = 1'b1;
            for (int k = 0; k < TL; k++) if (disk[b][k] != TAG_S[k]) ok = 1'b0;
            if (ok) begin
                exp_found = 1;
                exp_addr  = b;
                exp_reads = b + 1;
                for (int i = TL; i < 512; i++) exp_q2.push_back(disk[b][i]);
                for (int i = TL; i < 512; i++) begin
                    if (disk[b][i] == 8'h00) break;
                    exp_q1.push_back(disk[b][i]);
                end
                break;
            end
        end
        exp_len[0] = exp_q1.size();
        exp_len[1] = exp_q2.size();
    endtask

    // SD card responder: answers each read request with 512 bytes, with occasional idle beats
    initial begin
        int b, i;
        sd_out_valid = 1'b0;
        sd_dout      = 8'h00;
        forever begin
            @(negedge clk);
            if (reset && rq1) begin
                check("rd_addr", int'(addr1), rd_seen);
                check("rd_addr_nonul", int'(addr2), int'(addr1));
                b = int'(addr1[1:0]);
                rd_seen++;
                i = 0;
                @(posedge clk); #1;
                while (i < 512 && reset) begin
                    if ($urandom_range(0, 7) == 0) sd_out_valid = 1'b0;
                    else begin
                        sd_out_valid = 1'b1;
                        sd_dout      = disk[b][i];
                        i++;
                    end
                    @(posedge clk); #1;
                end
                sd_out_valid = 1'b0;
            end
        end
    end

    // Sink ready policy: 0 random, 1 twenty idle cycles per accept window, 2 always ready
    initial begin
        out_ready = 1'b0;
        slow_cnt  = 0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: out_ready = 1'($urandom_range(0, 1));
                1: begin
                    slow_cnt  = (slow_cnt + 1) % 21;
                    out_ready = (slow_cnt == 20);
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Compare process: stream contents, hold stability and end-of-scan results for both instances
    initial begin
        pr = 1'b0;
        for (int d = 0; d < 2; d++) begin
            pv[d] = 1'b0; pd[d] = 8'h00; done_cnt[d] = 0;
        end
        forever begin
            @(negedge clk);
            if (!reset) begin
                pv[0] = 1'b0;
                pv[1] = 1'b0;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    logic v, rq, dn, fd, bz;
                    logic [7:0]  od, e;
                    logic [31:0] ma;
                    int qs;
                    v  = (d == 0) ? ov1 : ov2;
                    od = (d == 0) ? od1 : od2;
                    rq = (d == 0) ? rq1 : rq2;
                    dn = (d == 0) ? dn1 : dn2;
                    fd = (d == 0) ? fd1 : fd2;
                    bz = (d == 0) ? busy1 : busy2;
                    ma = (d == 0) ? ma1 : ma2;
                    if (pv[d] && !pr) begin
                        check("hold_valid", int'(v), 1);
                        check("hold_data", int'(od), int'(pd[d]));
                    end
                    if (v) valid_cyc[d]++;
                    if (rq) rd_pulses[d]++;
                    if (v && out_ready) begin
                        qs = (d == 0) ? exp_q1.size() : exp_q2.size();
                        if (qs == 0) check("stream_extra", got_cnt[d] + 1, exp_len[d]);
                        else begin
                            e = (d == 0) ? exp_q1.pop_front() : exp_q2.pop_front();
                            check("out_data", int'(od), int'(e));
                        end
                        got_cnt[d]++;
                        last_byte[d] = od;
                    end
                    if (dn) begin
                        done_cnt[d]++;
                        check("done_found", int'(fd), exp_found);
                        if (exp_found != 0) check("done_match_addr", int'(ma), exp_addr);
                        check("done_leftover", (d == 0) ? exp_q1.size() : exp_q2.size(), 0);
                        check("done_busy", int'(bz), 1);
                    end
                    pv[d] = v;
                    pd[d] = od;
                end
            end
            pr = out_ready;
        end
    end

    task automatic run_scan(input int poke_at);
        int d0, d1, cyc;
        build_model();
        rd_seen = 0;
        for (int d = 0; d < 2; d++) begin
            rd_pulses[d] = 0; got_cnt[d] = 0; valid_cyc[d] = 0;
        end
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while ((done_cnt[0] == d0 || done_cnt[1] == d1) && cyc < 40000) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == poke_at);
        end
        start = 1'b0;
        check("scan_timeout", int'(cyc < 40000), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rd_pulses", rd_pulses[0], exp_reads);
        check("rd_pulses_nonul", rd_pulses[1], exp_reads);
        check("done_once", done_cnt[0], d0 + 1);
        check("done_once_nonul", done_cnt[1], d1 + 1);
        check("found_held", int'(fd1), exp_found);
        check("found_held_nonul", int'(fd2), exp_found);
        if (exp_found != 0) check("match_addr_held", int'(ma1), exp_addr);
        check("busy_after", int'(busy1), 0);
        check("stream_len", got_cnt[0], exp_len[0]);
        check("stream_len_nonul", got_cnt[1], exp_len[1]);
    endtask

    initial begin
        int d0, pos, nul;
        reset = 1'b0; start = 1'b0; sd_init_finish = 1'b1; ready_mode = 2;
        rd_seen = 0;
        for (int d = 0; d < 2; d++) begin
            rd_pulses[d] = 0; got_cnt[d] = 0; valid_cyc[d] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy1), 0);
        check("rst_rd_req", int'(rq1), 0);
        check("rst_addr", int'(addr1), 0);
        check("rst_valid", int'(ov1), 0);
        check("rst_done", int'(dn1), 0);
        check("rst_found", int'(fd1), 0);
        check("rst_match_addr", int'(ma1), 0);
        check("rst_busy_nonul", int'(busy2), 0);
        @(posedge clk); #1 reset = 1'b1;

        // start while the card is not initialised
        sd_init_finish = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("uninit_busy", int'(busy1), 0);
        check("uninit_rd", rd_pulses[0], 0);
        sd_init_finish = 1'b1;

        // tag with "HI" at block 3
        fill_random();
        put_tag(3, TL);
        put_payload(3, "HI");
        build_model();
        check("model_t1_len", exp_q1.size(), 2);
        check("model_t1_byte0", int'(exp_q1[0]), 8'h48);
        check("model_t1_reads", exp_reads, 4);
        run_scan(0);
        check("t1_found", int'(fd1), 1);
        check("t1_addr", int'(ma1), 3);
        check("t1_reads", rd_pulses[0], 4);
        check("t1_last", int'(last_byte[0]), 8'h49);

        // no tag anywhere
        fill_random();
        run_scan(0);
        check("t2_reads", rd_pulses[0], 4);
        check("t2_found", int'(fd1), 0);
        check("t2_valid_cycles", valid_cyc[0] + valid_cyc[1], 0);

        // slow sink
        ready_mode = 1;
        fill_random();
        put_tag(1, TL);
        put_payload(1, "SLOW!");
        run_scan(0);
        check("t3_len", got_cnt[0], 5);
        ready_mode = 0;

        // payload without NUL: full 504-byte stream
        fill_random();
        put_tag(2, TL);
        run_scan(0);
        check("t4_len", got_cnt[1], 512 - TL);
        check("t4_len_nul", got_cnt[0], 512 - TL);
        check("t4_last", int'(last_byte[1]), int'(disk[2][511]));

        // 7 of 8 signature bytes at block 0, full tag at block 1; empty payload
        fill_random();
        put_tag(0, TL - 1);
        put_tag(1, TL);
        put_payload(1, "");
        run_scan(0);
        check("t5_addr", int'(ma1), 1);
        check("t5_reads", rd_pulses[0], 2);
        check("t5_len", got_cnt[0], 0);

        // reset in the middle of reading, then a fresh scan with a start poke while busy
        fill_random();
        put_tag(2, TL);
        put_payload(2, "RST");
        build_model();
        rd_seen = 0;
        d0 = done_cnt[0];
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (200) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_rst_busy", int'(busy1), 0);
        check("mid_rst_addr", int'(addr1), 0);
        check("mid_rst_valid", int'(ov1), 0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("mid_rst_no_done", done_cnt[0], d0);
        run_scan(300);
        check("t6_addr", int'(ma1), 2);

        // randomized scans
        for (int r = 0; r < 5; r++) begin
            fill_random();
            pos = $urandom_range(0, MAXB);
            for (int b = 0; b < MAXB; b++)
                if (b != pos && $urandom_range(0, 1) == 1) put_tag(b, $urandom_range(0, TL - 1));
            if (pos < MAXB) begin
                put_tag(pos, TL);
                nul = $urandom_range(TL, 530);
                if (nul < 512) disk[pos][nul] = 8'h00;
            end
            ready_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            run_scan($urandom_range(50, 400));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
